// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// latches the instruction word, and traps on illegal opcodes or hung memories.
module multicycle_control #(
  parameter int unsigned ALU_OP_WIDTH   = 5,
  parameter int unsigned EXT_MODE_WIDTH = 3,
  parameter int unsigned NPC_MODE_WIDTH = 3,
  parameter int unsigned MEM_TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [31:0]               curr_instr,
  input  logic                      im_ready,
  input  logic                      dm_ready,
  input  logic                      alu_zero,
  output logic                      cm_rf_write_addr,
  output logic                      cm_rf_write_data,
  output logic                      cm_alu_num2,
  output logic [NPC_MODE_WIDTH-1:0] cw_npc_jump_mode,
  output logic                      cw_pc_enable,
  output logic                      cw_im_enable,
  output logic                      cw_rf_write_enable,
  output logic [ALU_OP_WIDTH-1:0]   cw_alu_op,
  output logic [EXT_MODE_WIDTH-1:0] cw_ext_mode,
  output logic                      cw_dm_read_enable,
  output logic                      cw_dm_write_enable,
  output logic [31:0]               ir,
  output logic [2:0]                state,
  output logic                      instr_done,
  output logic                      illegal_instr,
  output logic                      bus_error
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    I_ILLEGAL, I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J
  } instr_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [31:0]        r_ir;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_illegal;
  logic               r_bus_error;
  instr_t             w_cls;
  logic [5:0]         w_op;
  logic [5:0]         w_funct;
  logic               w_cnt_hit;
  logic               w_load_ir;
  logic               w_set_illegal;
  logic               w_set_timeout;

  assign w_op      = r_ir[31:26];
  assign w_funct   = r_ir[5:0];
  assign w_cnt_hit = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Classify the latched instruction word
  always_comb begin
    w_cls = I_ILLEGAL;
    if (r_ir == 32'h0000_0000) begin
      w_cls = I_NOP;
    end else begin
      case (w_op)
        6'h00: begin
          if (w_funct == 6'h21)      w_cls = I_ADDU;
          else if (w_funct == 6'h23) w_cls = I_SUBU;
        end
        6'h0D:   w_cls = I_ORI;
        6'h0F:   w_cls = I_LUI;
        6'h23:   w_cls = I_LW;
        6'h2B:   w_cls = I_SW;
        6'h04:   w_cls = I_BEQ;
        6'h02:   w_cls = I_J;
        default: w_cls = I_ILLEGAL;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next_state;
  end

  // Next-state logic; ready beats the watchdog on the final wait cycle
  always_comb begin
    w_next_state  = r_state;
    w_load_ir     = 1'b0;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (im_ready) begin
          w_next_state = S_DECODE;
          w_load_ir    = 1'b1;
        end else if (w_cnt_hit) begin
          w_next_state  = S_TRAP;
          w_set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_cls == I_ILLEGAL) begin
          w_next_state  = S_TRAP;
          w_set_illegal = 1'b1;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        case (w_cls)
          I_ADDU, I_SUBU, I_ORI, I_LUI: w_next_state = S_WB;
          I_LW, I_SW:                   w_next_state = S_MEM;
          default:                      w_next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dm_ready) begin
          w_next_state = (w_cls == I_LW) ? S_WB : S_FETCH;
        end else if (w_cnt_hit) begin
          w_next_state  = S_TRAP;
          w_set_timeout = 1'b1;
        end
      end
      S_WB:    w_next_state = S_FETCH;
      S_TRAP:  w_next_state = S_TRAP;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Instruction latch, watchdog counter and sticky error flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ir        <= 32'h0000_0000;
      r_cnt       <= '0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      if (w_load_ir) r_ir <= curr_instr;
      if (w_next_state != r_state) begin
        r_cnt <= '0;
      end else if (r_state == S_FETCH || r_state == S_MEM) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_set_illegal) r_illegal   <= 1'b1;
      if (w_set_timeout) r_bus_error <= 1'b1;
    end
  end

  // Per-state datapath controls, all forced low while reset is held
  always_comb begin
    cm_rf_write_addr   = 1'b0;
    cm_rf_write_data   = 1'b0;
    cm_alu_num2        = 1'b0;
    cw_npc_jump_mode   = '0;
    cw_pc_enable       = 1'b0;
    cw_im_enable       = 1'b0;
    cw_rf_write_enable = 1'b0;
    cw_alu_op          = '0;
    cw_ext_mode        = '0;
    cw_dm_read_enable  = 1'b0;
    cw_dm_write_enable = 1'b0;
    instr_done         = 1'b0;
    ir                 = r_ir;
    state              = r_state;
    illegal_instr      = r_illegal;
    bus_error          = r_bus_error;

    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      case (w_cls)
        I_SUBU, I_BEQ: cw_alu_op = ALU_OP_WIDTH'(1);
        I_ORI: begin
          cw_alu_op   = ALU_OP_WIDTH'(2);
          cm_alu_num2 = 1'b1;
          cw_ext_mode = EXT_MODE_WIDTH'(0);
        end
        I_LUI: begin
          cw_alu_op   = ALU_OP_WIDTH'(3);
          cm_alu_num2 = 1'b1;
          cw_ext_mode = EXT_MODE_WIDTH'(2);
        end
        I_LW, I_SW: begin
          cw_alu_op   = ALU_OP_WIDTH'(0);
          cm_alu_num2 = 1'b1;
          cw_ext_mode = EXT_MODE_WIDTH'(1);
        end
        default: ;
      endcase
    end

    case (r_state)
      S_FETCH: cw_im_enable = 1'b1;
      S_EXEC: begin
        if (w_cls == I_BEQ || w_cls == I_J || w_cls == I_NOP) begin
          cw_pc_enable = 1'b1;
          instr_done   = 1'b1;
          if (w_cls == I_BEQ)    cw_npc_jump_mode = NPC_MODE_WIDTH'(alu_zero);
          else if (w_cls == I_J) cw_npc_jump_mode = NPC_MODE_WIDTH'(2);
        end
      end
      S_MEM: begin
        cw_dm_read_enable  = (w_cls == I_LW);
        cw_dm_write_enable = (w_cls == I_SW);
        if (w_cls == I_SW && dm_ready) begin
          cw_pc_enable = 1'b1;
          instr_done   = 1'b1;
        end
      end
      S_WB: begin
        cw_rf_write_enable = 1'b1;
        cw_pc_enable       = 1'b1;
        instr_done         = 1'b1;
        cm_rf_write_addr   = (w_cls == I_ADDU || w_cls == I_SUBU);
        cm_rf_write_data   = (w_cls == I_LW);
      end
      default: ;
    endcase

    if (!reset_n) begin
      cm_rf_write_addr   = 1'b0;
      cm_rf_write_data   = 1'b0;
      cm_alu_num2        = 1'b0;
      cw_npc_jump_mode   = '0;
      cw_pc_enable       = 1'b0;
      cw_im_enable       = 1'b0;
      cw_rf_write_enable = 1'b0;
      cw_alu_op          = '0;
      cw_ext_mode        = '0;
      cw_dm_read_enable  = 1'b0;
      cw_dm_write_enable = 1'b0;
      instr_done         = 1'b0;
      ir                 = 32'h0000_0000;
      state              = 3'd0;
      illegal_instr      = 1'b0;
      bus_error          = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle MIPS control unit.
- FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and latches the instruction internally.
- Handshakes with instruction and data memories that have variable latency, with a watchdog counter that traps on a hung memory.
- Drives the same cm_/cw_ datapath controls, each qualified per state.

Parameters:
ALU_OP_WIDTH, 5, width of cw_alu_op
EXT_MODE_WIDTH, 3, width of cw_ext_mode
NPC_MODE_WIDTH, 3, width of cw_npc_jump_mode
MEM_TIMEOUT, 16, max cycles waiting on im_ready/dm_ready before trap (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
curr_instr  in  32  instruction word from IM, valid when im_ready=1
im_ready  in  1  IM data valid
dm_ready  in  1  DM read data valid / write accepted
alu_zero  in  1  ALU result == 0
cm_rf_write_addr  out  1  0=rt, 1=rd
cm_rf_write_data  out  1  0=ALU, 1=DM
cm_alu_num2  out  1  0=rf rt, 1=ext imm
cw_npc_jump_mode  out  NPC_MODE_WIDTH  0=PC+4, 1=branch offset, 2=j target
cw_pc_enable  out  1  PC update strobe
cw_im_enable  out  1  IM read request
cw_rf_write_enable  out  1  RF write strobe
cw_alu_op  out  ALU_OP_WIDTH  0=ADD, 1=SUB, 2=OR, 3=LUI
cw_ext_mode  out  EXT_MODE_WIDTH  0=zero, 1=sign, 2=upper
cw_dm_read_enable  out  1  DM read request
cw_dm_write_enable  out  1  DM write request
ir  out  32  latched instruction
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7
instr_done  out  1  one-cycle pulse when an instruction retires
illegal_instr  out  1  sticky; set on an undecodable instruction
bus_error  out  1  sticky; set on memory timeout

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=FETCH, ir=0, timeout counter=0, illegal_instr=0, bus_error=0.
  - All outputs are 0 while reset_n=0.
  - Reset in any state, including mid-MEM or TRAP, aborts the instruction without a PC or RF write.
- Decode (from ir):
  - addu: op 0, funct 0x21.
  - subu: op 0, funct 0x23.
  - nop: word 0.
  - ori: op 0x0D. lui: op 0x0F. lw: op 0x23. sw: op 0x2B. beq: op 0x04. j: op 0x02.
  - Anything else is illegal.
- FETCH:
  - cw_im_enable=1.
  - On im_ready=1: ir<=curr_instr, go to DECODE.
  - Otherwise the counter increments; reaching MEM_TIMEOUT sets bus_error and goes to TRAP.
- DECODE: one cycle. Illegal -> TRAP with illegal_instr=1; otherwise -> EXEC.
- EXEC controls:
  - addu: alu_op=0, num2=0.
  - subu: alu_op=1, num2=0.
  - ori: alu_op=2, num2=1, ext=0.
  - lui: alu_op=3, num2=1, ext=2.
  - lw/sw: alu_op=0, num2=1, ext=1.
  - beq: alu_op=1, num2=0.
- EXEC transitions:
  - addu/subu/ori/lui -> WB.
  - lw/sw -> MEM.
  - beq, j and nop are final here. The same cycle has pc_enable=1, instr_done=1, then -> FETCH.
    - beq: npc=1 if alu_zero else 0.
    - j: npc=2.
    - nop: npc=0.
- MEM:
  - lw holds cw_dm_read_enable=1; sw holds cw_dm_write_enable=1. Each is held until dm_ready.
  - EXEC controls stay stable during MEM.
  - On dm_ready: lw -> WB; sw retires in this cycle (pc_enable, npc=0, instr_done) -> FETCH.
  - The timeout rule is the same as FETCH. The counter is cleared on every state entry.
- WB:
  - rf_write_enable=1, pc_enable=1, npc=0, instr_done=1, then -> FETCH.
  - rd-writers (addu/subu): cm_rf_write_addr=1.
  - lw: cm_rf_write_data=1.
- TRAP:
  - Absorbing until reset.
  - All strobes (pc/im/rf/dm) are 0. illegal_instr and bus_error hold.
- Strobe timing: at most one pc_enable and one rf_write_enable pulse per instruction; none in FETCH or DECODE.
- Latency with ready=1 at first request:
  - beq/j/nop: 3 cycles.
  - sw: 4 cycles.
  - ALU ops: 4 cycles.
  - lw: 5 cycles.
  - Each stall cycle adds 1.
- If ready arrives on the same cycle the counter reaches MEM_TIMEOUT-1, ready wins.

Test Plan:
- Reset, im_ready=1, curr_instr=32'h00430821 (addu $1,$2,$3) -> states 0,1,2,4; WB has rf_we=1, addr_sel=1, alu_op=0; instr_done at cycle 4.
- lw 32'h8c410008 with dm_ready delayed 3 cycles -> dm_read_enable held 3 cycles + 1 ack cycle; ext=1, num2=1; WB with data_sel=1, addr_sel=0; total 8 cycles.
- beq 32'h114afff9 once with alu_zero=1 and once with alu_zero=0 -> EXEC has pc_enable=1, npc=1 and 0 respectively; rf_we never 1.
- sw 32'hac410010, dm_ready at first MEM cycle -> dm_we=1 for 1 cycle, pc_enable the same cycle, rf_we=0; 4 cycles total.
- im_ready held 0 with MEM_TIMEOUT=16 -> bus_error=1 after 16 FETCH cycles, state=7, all strobes 0 until reset_n=0 then FETCH.
- curr_instr=32'hfc000000 -> illegal_instr=1 at DECODE exit, TRAP; reset_n=0 pulsed during MEM of a lw -> no rf_we, state=0 next cycle.
